// File: rtl/lcd_pkg.sv
// Shared types, HD44780 command codes and timing helpers for the character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_PWR_WAIT = 3'd0,
    ST_INIT     = 3'd1,
    ST_IDLE     = 3'd2,
    ST_ADDR     = 3'd3,
    ST_CHAR     = 3'd4,
    ST_CLEAR    = 3'd5
  } ctl_state_t;

  typedef enum logic [2:0] {
    WR_IDLE  = 3'd0,
    WR_SETUP = 3'd1,
    WR_HIGH  = 3'd2,
    WR_GAP   = 3'd3,
    WR_POST  = 3'd4
  } wr_state_t;

  localparam logic [7:0] FSET      = 8'h28;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] SET_DDRAM = 8'h80;
  localparam logic [7:0] ROW1_BASE = 8'h40;

  localparam longint unsigned T_PWR_US  = 64'd15_000;
  localparam longint unsigned T_4100_US = 64'd4_100;
  localparam longint unsigned T_100_US  = 64'd100;
  localparam longint unsigned T_CMD_US  = 64'd40;
  localparam longint unsigned T_CLR_US  = 64'd1_640;
  localparam longint unsigned T_GAP_US  = 64'd1;

  // Whole clock cycles covering us microseconds, rounded up.
  function automatic logic [31:0] us_to_cyc(input longint unsigned hz, input longint unsigned us);
    longint unsigned cyc;
    cyc = (hz * us + 64'd999_999) / 64'd1_000_000;
    return cyc[31:0];
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// Drives one byte (two nibbles) or a single nibble onto the 4-bit LCD bus and
// pulses oDone once the requested post-write wait has elapsed.
module lcd_nibble_writer import lcd_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int E_CYC  = 12
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        iStart,
  input  logic [7:0]  iByte,
  input  logic        iRS,
  input  logic        iNibbleOnly,
  input  logic [31:0] iPostCyc,
  output logic        oE,
  output logic        oRS,
  output logic [3:0]  oD,
  output logic        oDone
);

  // The E-low gap must leave room for one hold cycle and two setup cycles.
  localparam logic [31:0] GAP_RAW  = us_to_cyc(64'(CLK_HZ), T_GAP_US);
  localparam logic [31:0] GAP_CYC  = (GAP_RAW < 32'd3) ? 32'd3 : GAP_RAW;
  localparam logic [31:0] GAP_LAST = GAP_CYC - 32'd3;
  localparam logic [31:0] E_LAST   = 32'(E_CYC - 1);

  wr_state_t   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] post_q, post_d;
  logic        e_q, e_d;
  logic        rs_q, rs_d;
  logic [3:0]  d_q, d_d;
  logic [3:0]  lo_q, lo_d;
  logic        second_q, second_d;
  logic        done_q, done_d;

  // Next-state logic for the E pulse sequencer.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    post_d   = post_q;
    e_d      = e_q;
    rs_d     = rs_q;
    d_d      = d_q;
    lo_d     = lo_q;
    second_d = second_q;
    done_d   = 1'b0;
    case (state_q)
      WR_IDLE: begin
        if (iStart) begin
          rs_d     = iRS;
          d_d      = iNibbleOnly ? iByte[3:0] : iByte[7:4];
          lo_d     = iByte[3:0];
          second_d = ~iNibbleOnly;
          post_d   = iPostCyc;
          cnt_d    = 32'd0;
          state_d  = WR_SETUP;
        end else begin
          cnt_d = 32'd0;
        end
      end
      WR_SETUP: begin
        if (cnt_q == 32'd1) begin
          e_d     = 1'b1;
          cnt_d   = 32'd0;
          state_d = WR_HIGH;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WR_HIGH: begin
        if (cnt_q == E_LAST) begin
          e_d     = 1'b0;
          cnt_d   = 32'd0;
          state_d = second_q ? WR_GAP : WR_POST;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WR_GAP: begin
        if (cnt_q == GAP_LAST) begin
          d_d      = lo_q;
          second_d = 1'b0;
          cnt_d    = 32'd0;
          state_d  = WR_SETUP;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      WR_POST: begin
        // Done is raised one cycle early so the owner sees it as the wait expires.
        if (cnt_q == post_q - 32'd2) begin
          done_d  = 1'b1;
          cnt_d   = 32'd0;
          state_d = WR_IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      default: begin
        e_d     = 1'b0;
        cnt_d   = 32'd0;
        state_d = WR_IDLE;
      end
    endcase
  end

  // Sequencer state and registered bus outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q  <= WR_IDLE;
      cnt_q    <= 32'd0;
      post_q   <= 32'd0;
      e_q      <= 1'b0;
      rs_q     <= 1'b0;
      d_q      <= 4'd0;
      lo_q     <= 4'd0;
      second_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      post_q   <= post_d;
      e_q      <= e_d;
      rs_q     <= rs_d;
      d_q      <= d_d;
      lo_q     <= lo_d;
      second_q <= second_d;
      done_q   <= done_d;
    end
  end

  assign oE    = e_q;
  assign oRS   = rs_q;
  assign oD    = d_q;
  assign oDone = done_q;

endmodule

// File: rtl/lcd_text_ctrl.sv
// HD44780 4-bit text controller: power-on init, host ready/valid character and
// clear interface, cursor tracking with automatic DDRAM re-addressing on wrap.
module lcd_text_ctrl import lcd_pkg::*; #(
  parameter int CLK_HZ = 50_000_000,
  parameter int COLS   = 16,
  parameter int ROWS   = 2,
  parameter int E_CYC  = 12
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iValid,
  input  logic [7:0] iChar,
  input  logic       iClear,
  output logic       oReady,
  output logic       oInitDone,
  output logic       oRow,
  output logic [5:0] oCol,
  output logic       oLCD_Enabled,
  output logic       oLCD_RegisterSelect,
  output logic       oLCD_ReadWrite,
  output logic       oLCD_StrataFlashControl,
  output logic [3:0] oLCD_Data
);

  localparam logic [31:0] PWR_CYC  = us_to_cyc(64'(CLK_HZ), T_PWR_US);
  localparam logic [31:0] T4100    = us_to_cyc(64'(CLK_HZ), T_4100_US);
  localparam logic [31:0] T100     = us_to_cyc(64'(CLK_HZ), T_100_US);
  localparam logic [31:0] CMD_CYC  = us_to_cyc(64'(CLK_HZ), T_CMD_US);
  localparam logic [31:0] CLR_CYC  = us_to_cyc(64'(CLK_HZ), T_CLR_US);
  // Start is issued early so the first E edge lands on the power-on deadline.
  localparam logic [31:0] PWR_LAST = PWR_CYC - 32'd4;
  localparam logic [5:0]  COL_LAST = 6'(COLS - 1);
  localparam logic        MULTI_ROW = (ROWS > 1);

  function automatic logic [7:0] init_code(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: return 8'h03;
      3'd3:             return 8'h02;
      3'd4:             return FSET;
      3'd5:             return ENTRY;
      3'd6:             return DISP_ON;
      3'd7:             return CLEAR;
      default:          return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] init_post(input logic [2:0] idx);
    case (idx)
      3'd0:    return T4100;
      3'd1:    return T100;
      3'd7:    return CLR_CYC;
      default: return CMD_CYC;
    endcase
  endfunction

  ctl_state_t  state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic        start_q, start_d;
  logic [7:0]  code_q, code_d;
  logic        rs_q, rs_d;
  logic        nib_only_q, nib_only_d;
  logic [31:0] post_q, post_d;
  logic [7:0]  char_q, char_d;
  logic        ready_q, ready_d;
  logic        init_done_q, init_done_d;
  logic        row_q, row_d;
  logic [5:0]  col_q, col_d;
  logic        pend_q, pend_d;
  logic        wr_done_s;
  logic [2:0]  idx_nx_s;

  assign idx_nx_s = idx_q + 3'd1;

  // Control FSM: init sequencing, host handshake and cursor bookkeeping.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    start_d     = 1'b0;
    code_d      = code_q;
    rs_d        = rs_q;
    nib_only_d  = nib_only_q;
    post_d      = post_q;
    char_d      = char_q;
    ready_d     = ready_q;
    init_done_d = init_done_q;
    row_d       = row_q;
    col_d       = col_q;
    pend_d      = pend_q;
    case (state_q)
      ST_PWR_WAIT: begin
        if (cnt_q == PWR_LAST) begin
          cnt_d      = 32'd0;
          idx_d      = 3'd0;
          start_d    = 1'b1;
          code_d     = init_code(3'd0);
          rs_d       = 1'b0;
          nib_only_d = 1'b1;
          post_d     = init_post(3'd0);
          state_d    = ST_INIT;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      ST_INIT: begin
        if (wr_done_s && (idx_q == 3'd7)) begin
          ready_d     = 1'b1;
          init_done_d = 1'b1;
          state_d     = ST_IDLE;
        end else if (wr_done_s) begin
          idx_d      = idx_nx_s;
          start_d    = 1'b1;
          code_d     = init_code(idx_nx_s);
          nib_only_d = (idx_nx_s < 3'd4);
          post_d     = init_post(idx_nx_s);
        end else begin
          cnt_d = 32'd0;
        end
      end
      ST_IDLE: begin
        if (ready_q && iClear) begin
          ready_d    = 1'b0;
          start_d    = 1'b1;
          code_d     = CLEAR;
          rs_d       = 1'b0;
          nib_only_d = 1'b0;
          post_d     = CLR_CYC;
          row_d      = 1'b0;
          col_d      = 6'd0;
          pend_d     = 1'b0;
          state_d    = ST_CLEAR;
        end else if (ready_q && iValid && pend_q) begin
          ready_d    = 1'b0;
          char_d     = iChar;
          start_d    = 1'b1;
          code_d     = SET_DDRAM | (row_q ? ROW1_BASE : 8'h00);
          rs_d       = 1'b0;
          nib_only_d = 1'b0;
          post_d     = CMD_CYC;
          pend_d     = 1'b0;
          state_d    = ST_ADDR;
        end else if (ready_q && iValid) begin
          ready_d    = 1'b0;
          char_d     = iChar;
          start_d    = 1'b1;
          code_d     = iChar;
          rs_d       = 1'b1;
          nib_only_d = 1'b0;
          post_d     = CMD_CYC;
          state_d    = ST_CHAR;
        end else begin
          ready_d = 1'b1;
        end
      end
      ST_ADDR: begin
        if (wr_done_s) begin
          start_d    = 1'b1;
          code_d     = char_q;
          rs_d       = 1'b1;
          nib_only_d = 1'b0;
          post_d     = CMD_CYC;
          state_d    = ST_CHAR;
        end else begin
          cnt_d = 32'd0;
        end
      end
      ST_CHAR: begin
        if (wr_done_s && (col_q == COL_LAST)) begin
          col_d   = 6'd0;
          row_d   = MULTI_ROW ? ~row_q : 1'b0;
          pend_d  = 1'b1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else if (wr_done_s) begin
          col_d   = col_q + 6'd1;
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = 32'd0;
        end
      end
      ST_CLEAR: begin
        if (wr_done_s) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = 32'd0;
        end
      end
      default: begin
        cnt_d   = 32'd0;
        ready_d = 1'b0;
        state_d = ST_PWR_WAIT;
      end
    endcase
  end

  // Control state and registered host-side outputs.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_PWR_WAIT;
      cnt_q       <= 32'd0;
      idx_q       <= 3'd0;
      start_q     <= 1'b0;
      code_q      <= 8'h00;
      rs_q        <= 1'b0;
      nib_only_q  <= 1'b0;
      post_q      <= 32'd0;
      char_q      <= 8'h00;
      ready_q     <= 1'b0;
      init_done_q <= 1'b0;
      row_q       <= 1'b0;
      col_q       <= 6'd0;
      pend_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      start_q     <= start_d;
      code_q      <= code_d;
      rs_q        <= rs_d;
      nib_only_q  <= nib_only_d;
      post_q      <= post_d;
      char_q      <= char_d;
      ready_q     <= ready_d;
      init_done_q <= init_done_d;
      row_q       <= row_d;
      col_q       <= col_d;
      pend_q      <= pend_d;
    end
  end

  lcd_nibble_writer #(
    .CLK_HZ (CLK_HZ),
    .E_CYC  (E_CYC)
  ) u_writer (
    .Clock       (Clock),
    .Reset       (Reset),
    .iStart      (start_q),
    .iByte       (code_q),
    .iRS         (rs_q),
    .iNibbleOnly (nib_only_q),
    .iPostCyc    (post_q),
    .oE          (oLCD_Enabled),
    .oRS         (oLCD_RegisterSelect),
    .oD          (oLCD_Data),
    .oDone       (wr_done_s)
  );

  assign oReady                  = ready_q;
  assign oInitDone               = init_done_q;
  assign oRow                    = row_q;
  assign oCol                    = col_q;
  assign oLCD_ReadWrite          = 1'b0;
  assign oLCD_StrataFlashControl = 1'b1;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// Directed self-checking bench for lcd_text_ctrl at a reduced clock rate.
module tb_lcd_text_ctrl;

  localparam int CLK_HZ = 500_000;
  localparam int COLS   = 16;
  localparam int ROWS   = 2;
  localparam int E_CYC  = 12;
  // Hand-derived at 500 kHz: 15 ms, 4.1 ms, 40 us, 1.64 ms, gap 1 us floored to 3.
  localparam int PWR    = 7500;
  localparam int T4100  = 2050;
  localparam int CMD    = 20;
  localparam int CLR    = 820;
  localparam int GAP    = 3;

  logic       Clock = 1'b0;
  logic       Reset = 1'b0;
  logic       iValid = 1'b0;
  logic       iClear = 1'b0;
  logic [7:0] iChar = 8'h00;
  logic       oReady, oInitDone, oRow;
  logic [5:0] oCol;
  logic       oLCD_Enabled, oLCD_RegisterSelect, oLCD_ReadWrite, oLCD_StrataFlashControl;
  logic [3:0] oLCD_Data;

  lcd_text_ctrl #(.CLK_HZ(CLK_HZ), .COLS(COLS), .ROWS(ROWS), .E_CYC(E_CYC)) dut (
    .Clock(Clock), .Reset(Reset), .iValid(iValid), .iChar(iChar), .iClear(iClear),
    .oReady(oReady), .oInitDone(oInitDone), .oRow(oRow), .oCol(oCol),
    .oLCD_Enabled(oLCD_Enabled), .oLCD_RegisterSelect(oLCD_RegisterSelect),
    .oLCD_ReadWrite(oLCD_ReadWrite), .oLCD_StrataFlashControl(oLCD_StrataFlashControl),
    .oLCD_Data(oLCD_Data)
  );

  always #5 Clock = ~Clock;

  int cyc = 0;
  always @(posedge Clock) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail = 0;
  logic [4:0] nib_log[$];
  int rise_c[$];
  int fall_c[$];
  int rdy_c = 0;
  int idone_c = 0;
  int acc_cyc = 0;
  logic [4:0] exp_init [12] = '{5'h03, 5'h03, 5'h03, 5'h02, 5'h02, 5'h08,
                                5'h00, 5'h06, 5'h00, 5'h0C, 5'h00, 5'h01};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] nib_at(input int i);
    if (i < nib_log.size()) return nib_log[i];
    else return 5'h1F;
  endfunction

  function automatic int rise_at(input int i);
    if (i < rise_c.size()) return rise_c[i];
    else return -1;
  endfunction

  function automatic int fall_at(input int i);
    if (i < fall_c.size()) return fall_c[i];
    else return -1;
  endfunction

  // Bus monitor: logs every nibble strobe and checks pulse shape.
  initial begin
    logic [4:0] s, s_p1, s_p2;
    logic e_prev, rdy_prev, idone_prev;
    s_p1 = 5'h00; s_p2 = 5'h00; e_prev = 1'b0; rdy_prev = 1'b0; idone_prev = 1'b0;
    forever begin
      @(negedge Clock);
      s = {oLCD_RegisterSelect, oLCD_Data};
      if (!Reset) begin
        e_prev = 1'b0; rdy_prev = 1'b0; idone_prev = 1'b0;
      end else begin
        if (oLCD_Enabled && !e_prev) begin
          nib_log.push_back(s);
          rise_c.push_back(cyc);
          check_eq("setup_stable", 32'({s_p1, s_p2}), 32'({s, s}));
        end
        if (!oLCD_Enabled && e_prev) begin
          fall_c.push_back(cyc);
          check_eq("e_high_width", 32'(cyc - rise_c[$]), 32'(E_CYC));
          check_eq("data_hold", 32'(s), 32'(nib_log[$]));
        end
        if (oReady && !rdy_prev) rdy_c = cyc;
        if (oInitDone && !idone_prev) idone_c = cyc;
        e_prev = oLCD_Enabled; rdy_prev = oReady; idone_prev = oInitDone;
      end
      s_p2 = s_p1; s_p1 = s;
    end
  end

  task automatic wait_ready(input int bound);
    int n = 0;
    while (!oReady && n < bound) begin
      @(negedge Clock);
      n++;
    end
    if (!oReady) check_eq("ready_timeout", 32'(oReady), 32'd1);
  endtask

  task automatic xfer(input logic [7:0] ch, input logic clr);
    wait_ready(2000);
    iValid = 1'b1; iChar = ch; iClear = clr;
    @(negedge Clock);
    acc_cyc = cyc;
    iValid = 1'b0; iClear = 1'b0;
    wait_ready(2000);
  endtask

  task automatic check_cursor(input string tag, input logic row, input logic [5:0] col);
    check_eq({tag, "_row"}, 32'(oRow), 32'(row));
    check_eq({tag, "_col"}, 32'(oCol), 32'(col));
  endtask

  task automatic check_nibs(input string tag, input int base, input logic [4:0] e0, input logic [4:0] e1);
    check_eq({tag, "_hi"}, 32'(nib_at(base)), 32'(e0));
    check_eq({tag, "_lo"}, 32'(nib_at(base + 1)), 32'(e1));
  endtask

  initial begin
    int base, rel, n;
    repeat (3) @(negedge Clock);
    check_eq("rst_e", 32'(oLCD_Enabled), 32'd0);
    check_eq("rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
    check_eq("rst_d", 32'(oLCD_Data), 32'd0);
    check_eq("rst_ready", 32'(oReady), 32'd0);
    check_eq("rst_initdone", 32'(oInitDone), 32'd0);
    check_cursor("rst", 1'b0, 6'd0);
    check_eq("rw_const", 32'(oLCD_ReadWrite), 32'd0);
    check_eq("sf_const", 32'(oLCD_StrataFlashControl), 32'd1);

    Reset = 1'b1; rel = cyc; n = 0;
    while (!oLCD_Enabled && n < PWR + 20) begin @(negedge Clock); n++; end
    check_eq("first_e_delay", 32'((cyc - rel >= PWR - 1) && (cyc - rel <= PWR + 1)), 32'd1);
    n = 0;
    while (!oInitDone && n < 20000) begin @(negedge Clock); n++; end
    check_eq("initdone_reached", 32'(oInitDone), 32'd1);
    check_eq("init_nibble_count", 32'(nib_log.size()), 32'd12);
    for (int i = 0; i < 12; i++) check_eq("init_nibble", 32'(nib_at(i)), 32'(exp_init[i]));
    check_eq("wait_4100", 32'(rise_at(1) - fall_at(0)), 32'(T4100 + 3));
    check_eq("initdone_delay", 32'(idone_c - fall_at(11)), 32'(CLR));
    check_eq("ready_after_init", 32'(oReady), 32'd1);

    base = nib_log.size();
    xfer(8'h41, 1'b0);
    check_eq("char_count", 32'(nib_log.size() - base), 32'd2);
    check_nibs("char_A", base, 5'h14, 5'h11);
    check_eq("accept_to_e", 32'(rise_at(base) - acc_cyc), 32'd3);
    check_eq("nibble_gap", 32'(rise_at(base + 1) - fall_at(base)), 32'(GAP));
    check_eq("ready_post_char", 32'(rdy_c - fall_at(base + 1)), 32'(CMD));
    check_cursor("after_A", 1'b0, 6'd1);

    base = nib_log.size();
    xfer(8'h55, 1'b1);
    check_eq("clear_count", 32'(nib_log.size() - base), 32'd2);
    check_nibs("clear_byte", base, 5'h00, 5'h01);
    check_eq("clear_wait", 32'(rdy_c - fall_at(base + 1)), 32'(CLR));
    check_cursor("after_clear", 1'b0, 6'd0);

    for (int i = 0; i < 16; i++) xfer(8'h61 + 8'(i), 1'b0);
    check_cursor("after_16", 1'b1, 6'd0);
    base = nib_log.size();
    xfer(8'h71, 1'b0);
    check_eq("wrap1_count", 32'(nib_log.size() - base), 32'd4);
    check_nibs("wrap1_addr", base, 5'h0C, 5'h00);
    check_nibs("wrap1_char", base + 2, 5'h17, 5'h11);
    check_cursor("after_17", 1'b1, 6'd1);

    for (int i = 0; i < 14; i++) xfer(8'h30 + 8'(i), 1'b0);
    check_cursor("row1_col15", 1'b1, 6'd15);
    base = nib_log.size();
    xfer(8'h42, 1'b0);
    xfer(8'h43, 1'b0);
    check_eq("wrap0_count", 32'(nib_log.size() - base), 32'd6);
    check_nibs("wrap0_first", base, 5'h14, 5'h12);
    check_nibs("wrap0_addr", base + 2, 5'h08, 5'h00);
    check_nibs("wrap0_second", base + 4, 5'h14, 5'h13);
    check_cursor("after_wrap0", 1'b0, 6'd1);

    wait_ready(2000);
    iValid = 1'b1; iChar = 8'h41;
    @(negedge Clock);
    iValid = 1'b0;
    n = 0;
    while (!oLCD_Enabled && n < 50) begin @(negedge Clock); n++; end
    check_eq("e_high_before_reset", 32'(oLCD_Enabled), 32'd1);
    #2 Reset = 1'b0;
    #1;
    check_eq("async_rst_e", 32'(oLCD_Enabled), 32'd0);
    check_eq("async_rst_rs", 32'(oLCD_RegisterSelect), 32'd0);
    check_eq("async_rst_d", 32'(oLCD_Data), 32'd0);
    check_eq("async_rst_ready", 32'(oReady), 32'd0);
    check_eq("async_rst_initdone", 32'(oInitDone), 32'd0);
    check_cursor("async_rst", 1'b0, 6'd0);
    repeat (3) @(negedge Clock);
    Reset = 1'b1; rel = cyc; n = 0;
    while (!oLCD_Enabled && n < PWR + 20) begin @(negedge Clock); n++; end
    check_eq("restart_pwr_delay", 32'((cyc - rel >= PWR - 1) && (cyc - rel <= PWR + 1)), 32'd1);
    check_eq("restart_first_nibble", 32'({oLCD_RegisterSelect, oLCD_Data}), 32'h03);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
